// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two write-back requesters, each with its own FIFO.
// Round-robin selects one FIFO head per cycle onto a registered write port, with read-hazard lookup.
module regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        wen,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        grant_id,
    input  logic [4:0]  query_addr_0,
    input  logic [4:0]  query_addr_1,
    output logic        hazard_0,
    output logic        hazard_1,
    output logic        idle
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    fifoAddr_q [2][DEPTH];
    logic [31:0]   fifoData_q [2][DEPTH];
    logic [AW-1:0] rdPtr_q [2];
    logic [AW-1:0] wrPtr_q [2];
    logic [AW:0]   count_q [2];
    logic          prio_q;
    logic          wen_q;
    logic [4:0]    writeAddr_q;
    logic [31:0]   writeData_q;
    logic          grantId_q;

    logic [1:0]    inValid, full, empty, push, pop;
    logic [4:0]    inAddr [2];
    logic [31:0]   inData [2];
    logic          popAny, winner;
    logic [4:0]    headAddr;
    logic [31:0]   headData;

    // prio_q names the requester that wins a tie; a lone non-empty FIFO always wins.
    always_comb begin
        inValid   = {req1_valid, req0_valid};
        inAddr[0] = req0_addr;
        inAddr[1] = req1_addr;
        inData[0] = req0_data;
        inData[1] = req1_data;
        for (int n = 0; n < 2; n++) begin
            full[n]  = (count_q[n] == DEPTH[AW:0]);
            empty[n] = (count_q[n] == '0);
        end
        push   = inValid & ~full;
        popAny = ~&empty;
        winner = (~|empty) ? prio_q : empty[0];
        pop    = '0;
        if (popAny) begin
            pop[winner] = 1'b1;
        end
        headAddr = fifoAddr_q[winner][rdPtr_q[winner]];
        headData = fifoData_q[winner][rdPtr_q[winner]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                rdPtr_q[n] <= '0;
                wrPtr_q[n] <= '0;
                count_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    wrPtr_q[n] <= wrPtr_q[n] + 1'b1;
                end
                if (pop[n]) begin
                    rdPtr_q[n] <= rdPtr_q[n] + 1'b1;
                end
                if (push[n] && !pop[n]) begin
                    count_q[n] <= count_q[n] + 1'b1;
                end else if (pop[n] && !push[n]) begin
                    count_q[n] <= count_q[n] - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: the counts alone decide which slots are live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                fifoAddr_q[n][wrPtr_q[n]] <= inAddr[n];
                fifoData_q[n][wrPtr_q[n]] <= inData[n];
            end
        end
    end

    // Writes to r0 still retire a slot but never raise the enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q      <= 1'b0;
            wen_q       <= 1'b0;
            writeAddr_q <= '0;
            writeData_q <= '0;
            grantId_q   <= 1'b0;
        end else if (popAny) begin
            prio_q      <= ~winner;
            wen_q       <= (headAddr != 5'd0);
            writeAddr_q <= headAddr;
            writeData_q <= headData;
            grantId_q   <= winner;
        end else begin
            wen_q <= 1'b0;
        end
    end

    function automatic logic pendingMatch(input logic [4:0] q);
        logic          hit;
        logic [AW-1:0] idx;
        logic [AW-1:0] offset;
        hit = wen_q && (writeAddr_q == q);
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx    = i[AW-1:0];
                offset = idx - rdPtr_q[n];
                if (({1'b0, offset} < count_q[n]) && (fifoAddr_q[n][i] == q)) begin
                    hit = 1'b1;
                end
            end
        end
        return (q != 5'd0) && hit;
    endfunction

    assign req0_ready = ~full[0];
    assign req1_ready = ~full[1];
    assign wen        = wen_q;
    assign write_addr = writeAddr_q;
    assign write_data = writeData_q;
    assign grant_id   = grantId_q;
    assign hazard_0   = pendingMatch(query_addr_0);
    assign hazard_1   = pendingMatch(query_addr_1);
    assign idle       = (&empty) && !wen_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter, checked against a queue-based
// transaction model of the two FIFOs, the round-robin choice and the registered write port.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        wen, grant_id;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  query_addr_0, query_addr_1;
    logic        hazard_0, hazard_1, idle;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .wen(wen), .write_addr(write_addr), .write_data(write_data), .grant_id(grant_id),
        .query_addr_0(query_addr_0), .query_addr_1(query_addr_1),
        .hazard_0(hazard_0), .hazard_1(hazard_1), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        int         cyc;
        logic       gid;
        logic [4:0] addr;
    } logEntry_t;

    entry_t      q0[$];
    entry_t      q1[$];
    logEntry_t   writeLog[$];
    logic        mWen, mGrant, mPrio;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycleCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic expHazard(input logic [4:0] qa);
        if (qa == 5'd0) return 1'b0;
        if (mWen && mAddr == qa) return 1'b1;
        foreach (q0[i]) if (q0[i].addr == qa) return 1'b1;
        foreach (q1[i]) if (q1[i].addr == qa) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model past the edge.
    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [4:0] qa0, input logic [4:0] qa1,
                                 output logic acc0, output logic acc1);
        entry_t e;
        logic   win, r0, r1;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        query_addr_0 = qa0; query_addr_1 = qa1;
        #1;
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        checkOutput("req0_ready", req0_ready, r0);
        checkOutput("req1_ready", req1_ready, r1);
        checkOutput("wen", wen, mWen);
        if (mWen) begin
            checkOutput("write_addr", write_addr, mAddr);
            checkOutput("write_data", write_data, mData);
            checkOutput("grant_id", grant_id, mGrant);
        end
        checkOutput("hazard_0", hazard_0, expHazard(qa0));
        checkOutput("hazard_1", hazard_1, expHazard(qa1));
        checkOutput("idle", idle, (q0.size() == 0) && (q1.size() == 0) && !mWen);
        if (wen) writeLog.push_back('{cycleCount, grant_id, write_addr});
        @(posedge clk);
        cycleCount++;
        if (q0.size() != 0 || q1.size() != 0) begin
            win    = (q0.size() != 0 && q1.size() != 0) ? mPrio : (q0.size() == 0);
            e      = win ? q1.pop_front() : q0.pop_front();
            mWen   = (e.addr != 5'd0);
            mAddr  = e.addr;
            mData  = e.data;
            mGrant = win;
            mPrio  = !win;
        end else begin
            mWen = 1'b0;
        end
        acc0 = v0 && r0;
        acc1 = v1 && r1;
        if (acc0) q0.push_back({a0, d0});
        if (acc1) q1.push_back({a1, d1});
    endtask

    task automatic idleCycles(input int n, input logic [4:0] qa0, input logic [4:0] qa1);
        logic a0, a1;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, qa0, qa1, a0, a1);
    endtask

    // Reset lands between edges so its effect is checked before any clock arrives.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        req0_valid = 0; req1_valid = 0;
        #1;
        checkOutput("rst_wen", wen, 0);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_ready0", req0_ready, 1);
        checkOutput("rst_ready1", req1_ready, 1);
        checkOutput("rst_addr", write_addr, 0);
        checkOutput("rst_data", write_data, 0);
        checkOutput("rst_grant", grant_id, 0);
        q0.delete(); q1.delete(); writeLog.delete();
        mWen = 0; mAddr = 0; mData = 0; mGrant = 0; mPrio = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic       a0, a1;
        logic [4:0] exp0 [3];
        logic [4:0] exp1 [3];
        logic [4:0] seqAddr [6];
        int         i0, i1, n0, n1, sawFull;

        reset = 1'b0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        query_addr_0 = 0; query_addr_1 = 0;
        #2;
        checkOutput("init_wen", wen, 0);
        checkOutput("init_idle", idle, 1);
        checkOutput("init_ready0", req0_ready, 1);
        checkOutput("init_hazard0", hazard_0, 0);
        doReset();

        // Single write, two-cycle latency.
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, a0, a1);
        idleCycles(4, 5, 0);
        checkOutput("single_count", writeLog.size(), 1);
        if (writeLog.size() == 1) begin
            checkOutput("single_addr", writeLog[0].addr, 5);
            checkOutput("single_gid", writeLog[0].gid, 0);
            checkOutput("single_latency", writeLog[0].cyc, 2);
        end

        // Contention from reset.
        doReset();
        exp0 = '{5'd1, 5'd2, 5'd3};
        exp1 = '{5'd9, 5'd10, 5'd11};
        seqAddr = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        i0 = 0; i1 = 0;
        for (int k = 0; k < 20 && (i0 < 3 || i1 < 3); k++) begin
            applyStimulus(i0 < 3, exp0[i0 % 3], $urandom, i1 < 3, exp1[i1 % 3], $urandom, 0, 0, a0, a1);
            if (a0) i0++;
            if (a1) i1++;
        end
        idleCycles(6, 0, 0);
        checkOutput("contend_count", writeLog.size(), 6);
        for (int k = 0; k < writeLog.size() && k < 6; k++) begin
            checkOutput("contend_addr", writeLog[k].addr, seqAddr[k]);
            checkOutput("contend_gid", writeLog[k].gid, k % 2);
            if (k > 0) checkOutput("contend_gap", writeLog[k].cyc - writeLog[k-1].cyc, 1);
        end

        // Backpressure on requester 1 while requester 0 floods.
        doReset();
        i1 = 0; n0 = 0; sawFull = 0;
        for (int k = 0; k < 12; k++) begin
            if (!req1_ready) sawFull = 1;
            applyStimulus(1, 5'(1 + k % 15), $urandom, i1 < 3, 5'(20 + i1), $urandom, 0, 0, a0, a1);
            if (a0) n0++;
            if (a1) i1++;
        end
        idleCycles(8, 0, 0);
        checkOutput("bp_saw_full", sawFull, 1);
        checkOutput("bp_req1_sent", i1, 3);
        n1 = 0;
        foreach (writeLog[k]) if (writeLog[k].gid) begin
            checkOutput("bp_req1_order", writeLog[k].addr, 20 + n1);
            n1++;
        end
        checkOutput("bp_req1_count", n1, 3);
        checkOutput("bp_req0_count", writeLog.size() - n1, n0);

        // Zero-register write consumes its slot silently.
        doReset();
        applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0, a0, a1);
        idleCycles(4, 0, 0);
        checkOutput("zero_count", writeLog.size(), 0);

        // Hazard tracking on a buffered requester-1 write.
        doReset();
        applyStimulus(0, 0, 0, 1, 7, 32'h77, 7, 0, a0, a1);
        idleCycles(5, 7, 0);

        // Reset mid-flight drops everything buffered.
        doReset();
        applyStimulus(1, 3, 32'h3, 1, 4, 32'h4, 0, 0, a0, a1);
        applyStimulus(1, 6, 32'h6, 1, 8, 32'h8, 0, 0, a0, a1);
        doReset();
        idleCycles(5, 3, 4);
        checkOutput("midrst_stale", writeLog.size(), 0);

        // Random traffic.
        doReset();
        for (int k = 0; k < 400; k++) begin
            if (k % 97 == 96) doReset();
            applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a0, a1);
        end
        idleCycles(6, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
